// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous memory between the instruction-fetch and load/store ports.
// Data accesses win by default; a saturating streak counter gives a waiting fetch one grant after MAX_DATA_STREAK data grants.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req,
    input  logic [29:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic [29:0] i_ls_addr,
    input  logic        i_ls_we,
    input  logic [3:0]  i_ls_mask,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,
    output logic        o_mem_en,
    output logic [29:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_mask,
    output logic [31:0] o_mem_data,
    input  logic [31:0] i_mem_data
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_owner_q, rsp_owner_d;  // 0 = fetch, 1 = load/store
    logic       force_if;

    always_comb begin
        force_if = i_if_req && (streak_q == STREAK_MAX);
        o_ls_gnt = i_ls_req && !force_if;
        o_if_gnt = i_if_req && !o_ls_gnt;
    end

    always_comb begin
        o_mem_en   = 1'b0;
        o_mem_addr = '0;
        o_mem_we   = 1'b0;
        o_mem_mask = '0;
        o_mem_data = '0;
        if (o_ls_gnt) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_ls_addr;
            o_mem_we   = i_ls_we;
            o_mem_mask = i_ls_mask;
            o_mem_data = i_ls_wdata;
        end else if (o_if_gnt) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_if_addr;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_if_req || o_if_gnt) begin
            streak_d = '0;
        end else if (o_ls_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Stores complete in their grant cycle, so only reads schedule a response.
    always_comb begin
        rsp_valid_d = o_if_gnt || (o_ls_gnt && !i_ls_we);
        rsp_owner_d = o_ls_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign o_if_rvalid = rsp_valid_q && !rsp_owner_q;
    assign o_ls_rvalid = rsp_valid_q &&  rsp_owner_q;
    assign o_if_rdata  = i_mem_data;
    assign o_ls_rdata  = i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus for mem_arbiter, checked against a starvation-count reference model
// and a word-array memory model that predicts every grant, memory drive and returned read word.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [29:0] i_if_addr = '0;
    logic        o_if_gnt, o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_ls_req = 1'b0;
    logic [29:0] i_ls_addr = '0;
    logic        i_ls_we = 1'b0;
    logic [3:0]  i_ls_mask = '0;
    logic [31:0] i_ls_wdata = '0;
    logic        o_ls_gnt, o_ls_rvalid;
    logic [31:0] o_ls_rdata;
    logic        o_mem_en, o_mem_we;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_mask;
    logic [31:0] o_mem_data;
    logic [31:0] i_mem_data = '0;

    mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_we(i_ls_we),
        .i_ls_mask(i_ls_mask), .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
        .o_mem_mask(o_mem_mask), .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Environment memory: one-cycle read latency, byte-masked writes.
    logic [31:0] mem_arr [64];
    logic        preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
        end else if (o_mem_en) begin
            if (o_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_mask[b]) mem_arr[o_mem_addr[5:0]][8*b +: 8] <= o_mem_data[8*b +: 8];
            end else begin
                i_mem_data <= mem_arr[o_mem_addr[5:0]];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          starve = 0;       // data grants taken while the current fetch waited
    bit          pend_valid = 0, pend_ls = 0;
    logic [31:0] pend_data = '0;
    bit          m_if_gnt, m_ls_gnt;
    logic        obs_if_gnt, obs_ls_gnt;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Checks one cycle at its negedge, advances the model, returns 1 time unit after the next posedge.
    task automatic cycle();
        bit          e_if, e_ls;
        logic [29:0] e_addr;
        @(negedge clk);
        obs_if_gnt = o_if_gnt;
        obs_ls_gnt = o_ls_gnt;
        chk("if_rvalid", o_if_rvalid, pend_valid && !pend_ls);
        chk("ls_rvalid", o_ls_rvalid, pend_valid && pend_ls);
        chk("both_rvalid", o_if_rvalid & o_ls_rvalid, 0);
        if (pend_valid) chk(pend_ls ? "ls_rdata" : "if_rdata", pend_ls ? o_ls_rdata : o_if_rdata, pend_data);
        e_if = i_if_req && (!i_ls_req || starve >= MAX);
        e_ls = i_ls_req && !e_if;
        chk("if_gnt", o_if_gnt, e_if);
        chk("ls_gnt", o_ls_gnt, e_ls);
        chk("mem_en", o_mem_en, e_if | e_ls);
        e_addr = e_ls ? i_ls_addr : (e_if ? i_if_addr : 30'd0);
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_we", o_mem_we, e_ls && i_ls_we);
        chk("mem_mask", o_mem_mask, e_ls ? i_ls_mask : 4'd0);
        chk("mem_data", o_mem_data, e_ls ? i_ls_wdata : 32'd0);
        pend_valid = e_if || (e_ls && !i_ls_we);
        pend_ls    = e_ls;
        pend_data  = ref_mem[e_addr[5:0]];
        if (e_ls && i_ls_we)
            for (int b = 0; b < 4; b++)
                if (i_ls_mask[b]) ref_mem[e_addr[5:0]][8*b +: 8] = i_ls_wdata[8*b +: 8];
        if (!i_if_req || e_if) starve = 0;
        else if (e_ls) starve++;
        m_if_gnt = e_if;
        m_ls_gnt = e_ls;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_if_req = 0;
        i_ls_req = 0;
        rst_n = 0;
        #1;
        chk("rst_if_rvalid", o_if_rvalid, 0);
        chk("rst_ls_rvalid", o_ls_rvalid, 0);
        chk("rst_mem_en", o_mem_en, 0);
        pend_valid = 0;
        starve = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [29:0] a);
        i_ls_req = 1; i_ls_addr = a; i_ls_we = 0; i_ls_mask = 4'h0; i_ls_wdata = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        #2;
        chk("reset_if_rvalid", o_if_rvalid, 0);
        chk("reset_ls_rvalid", o_ls_rvalid, 0);
        @(posedge clk);
        #1;
        preload = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Fetch alone
        i_if_req = 1; i_if_addr = 30'h4;
        cycle();
        i_if_req = 0;
        chk("fetch_rvalid", o_if_rvalid, 1);
        chk("fetch_rdata", o_if_rdata, 32'hDEADBEEF);
        cycle();

        // Store, then read it back to see the byte mask took effect
        i_ls_req = 1; i_ls_we = 1; i_ls_mask = 4'b0011; i_ls_addr = 30'h20; i_ls_wdata = 32'h12345678;
        cycle();
        chk("store_gnt", obs_ls_gnt, 1);
        set_load(30'h20);
        cycle();
        i_ls_req = 0;
        cycle();

        // Back-to-back alternating load / fetch / load
        set_load(30'h3);
        cycle();
        i_ls_req = 0; i_if_req = 1; i_if_addr = 30'h7;
        cycle();
        i_if_req = 0; set_load(30'h9);
        cycle();
        i_ls_req = 0;
        cycle();

        // Contention: fetch gets every fifth slot
        i_if_req = 1; i_if_addr = 30'h11; set_load(30'h12);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("contention_if_gnt", obs_if_gnt, (k % 5) == 4);
        end
        i_if_req = 0; i_ls_req = 0;
        cycle();

        // Idle fetch: streak must not build while no fetch waits
        set_load(30'h15);
        for (int k = 0; k < 10; k++) cycle();
        i_if_req = 1; i_if_addr = 30'h16;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("idle_then_if_gnt", obs_if_gnt, k == 4);
        end
        i_if_req = 0; i_ls_req = 0;
        cycle();

        // Reset while a fetch read is in flight
        i_if_req = 1; i_if_addr = 30'h10;
        cycle();
        chk("pre_reset_rvalid", o_if_rvalid, 1);
        do_reset();
        cycle();
        cycle();

        // Streak restarts from zero after reset
        i_if_req = 1; i_if_addr = 30'h1; set_load(30'h2);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_reset_if_gnt", obs_if_gnt, k == 4);
        end
        i_if_req = 0; i_ls_req = 0;
        cycle();

        // Random traffic obeying the hold-until-granted handshake
        for (int n = 0; n < 600; n++) begin
            if (!i_if_req && $urandom_range(0, 2) != 0) begin
                i_if_req = 1; i_if_addr = 30'($urandom_range(0, 63));
            end
            if (!i_ls_req && $urandom_range(0, 3) != 0) begin
                i_ls_req = 1; i_ls_addr = 30'($urandom_range(0, 63));
                i_ls_we = ($urandom_range(0, 2) == 0);
                i_ls_mask = 4'($urandom); i_ls_wdata = $urandom;
            end
            cycle();
            if (m_if_gnt) i_if_req = 0;
            if (m_ls_gnt) i_ls_req = 0;
        end
        i_if_req = 0; i_ls_req = 0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported synchronous memory between the core's instruction-fetch port and its load/store port.
- The memory has one-cycle read latency.
- Each cycle the block grants at most one requester, drives the memory, and routes read data back to the granted requester one cycle later.
- Data accesses win by default. A streak counter prevents fetch starvation.

Parameters:
- MAX_DATA_STREAK, 4: number of consecutive data grants allowed while a fetch is waiting. After that, the fetch must be granted once. Legal range 1..15.

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_if_req  in  1  fetch request. Held until granted.
- i_if_addr  in  30  fetch word address.
- o_if_gnt  out  1  fetch is granted this cycle (combinational).
- o_if_rvalid  out  1  o_if_rdata is valid this cycle.
- o_if_rdata  out  32  fetch read data.
- i_ls_req  in  1  load/store request. Held until granted.
- i_ls_addr  in  30  load/store word address.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_mask  in  4  byte-enable mask for stores.
- i_ls_wdata  in  32  store data.
- o_ls_gnt  out  1  load/store is granted this cycle (combinational).
- o_ls_rvalid  out  1  o_ls_rdata is valid this cycle.
- o_ls_rdata  out  32  load read data.
- o_mem_en  out  1  memory access is active this cycle.
- o_mem_addr  out  30  memory word address.
- o_mem_we  out  1  memory write enable.
- o_mem_mask  out  4  memory byte mask.
- o_mem_data  out  32  memory write data.
- i_mem_data  in  32  memory read data. Valid one cycle after an o_mem_en read.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - streak counter = 0.
  - rsp_valid = 0, rsp_owner = 0.
  - o_if_rvalid = 0 and o_ls_rvalid = 0 immediately.
  - Any read in flight when reset asserts is dropped; no rvalid is produced for it after reset releases.
- Arbitration (combinational, same cycle as the request):
  - force_if = i_if_req && (streak == MAX_DATA_STREAK).
  - o_ls_gnt = i_ls_req && !force_if.
  - o_if_gnt = i_if_req && !o_ls_gnt.
  - At most one grant per cycle. With no request, both grants are 0 and o_mem_en = 0.
- Memory drive:
  - Granted requester's addr, we, mask and wdata are driven to o_mem_*.
  - A fetch grant drives o_mem_we = 0 and o_mem_mask = 4'b0000.
  - No grant: o_mem_en = 0, o_mem_we = 0, o_mem_mask = 0; address and data are don't-care but held at 0.
  - o_mem_we must never be 1 without o_mem_en.
- Streak counter:
  - Data grant while i_if_req = 1: increment, saturating at MAX_DATA_STREAK.
  - Fetch grant: clear to 0.
  - No fetch request pending: clear to 0.
  - Counter width is 4 bits.
- Response path:
  - On a grant that is a read (fetch, or load with we = 0): next cycle rsp_valid = 1 and rsp_owner = the granted requester; otherwise rsp_valid = 0.
  - o_if_rvalid = rsp_valid && owner is fetch. o_ls_rvalid = rsp_valid && owner is load/store.
  - Both rdata outputs drive i_mem_data combinationally.
  - Stores produce no rvalid. A store completes in its grant cycle.
- Pipelining:
  - Back-to-back grants are allowed every cycle.
  - A response and a new grant may occur in the same cycle, for either requester, with no bubble.
- Handshake rules:
  - A requester must hold req/addr/we/mask/wdata stable until it sees gnt = 1.
  - The arbiter takes no action on a request that is withdrawn before it is granted.
- Simultaneous requests with streak < MAX: data wins. With streak == MAX: fetch wins exactly once, then the counter restarts.

Test Plan:
- Reset mid-read: grant a fetch read at addr 0x10, assert rst_n = 0 the next cycle -> o_if_rvalid = 0, streak = 0, o_mem_en = 0 while in reset; no late rvalid after release.
- Fetch alone: i_if_req = 1, addr = 0x4, mem returns 0xDEADBEEF -> o_if_gnt = 1 and o_mem_en = 1 in cycle N; o_if_rvalid = 1 with rdata 0xDEADBEEF in N+1; o_ls_rvalid = 0.
- Store: i_ls_req = 1, we = 1, mask = 4'b0011, addr = 0x20, wdata = 0x12345678 -> same cycle o_ls_gnt = 1, o_mem_we = 1, mask 0011, data 0x12345678; no rvalid in N+1.
- Contention: both requests held continuously, loads only, MAX_DATA_STREAK = 4 -> grant sequence LS, LS, LS, LS, IF, LS, LS, LS, LS, IF...; each rvalid goes to the matching owner one cycle after its grant.
- Back-to-back alternating: load in N, fetch in N+1, load in N+2 -> o_ls_rvalid in N+1, o_if_rvalid in N+2, o_ls_rvalid in N+3; never both rvalids in one cycle.
- Idle fetch: data requests only for 10 cycles, i_if_req = 0 -> streak stays 0; a fetch arriving in cycle 11 together with a load loses to the load; the streak then counts from 1.
